// File: rtl/exe_muldiv.sv
// RV32M multiply/divide unit sitting behind the ID/EX register.
// Latency: MUL family 2 cycles, DIV family 33 cycles, divide special cases 1 cycle.
// Backpressure: hold_o freezes the upstream pipeline from start until the result (DONE) cycle.
module exe_muldiv #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [31:0]        inst_i,
    input  logic               reg_we_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               flush_i,
    output logic               hold_o,
    output logic               result_valid_o,
    output logic [XLEN-1:0]    result_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_nxt;

    // Captured operation context
    logic [XLEN-1:0]    a_q;        // op1 for MUL, dividend magnitude / quotient shift reg for DIV
    logic [XLEN-1:0]    b_q;        // op2 for MUL, divisor magnitude for DIV
    logic [XLEN-1:0]    rem_q;
    logic [2:0]         f3_q;
    logic               we_q;
    logic [RADDR_W-1:0] rd_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [CNT_W-1:0]   cnt_q;

    // Decode of the instruction currently in ID/EX
    logic       is_m, start, div_zero, div_ovf, div_special, is_signed_div;
    logic [2:0] f3_in;
    logic [XLEN-1:0] special_res, op1_mag, op2_mag;
    logic unused_inst;

    assign is_m          = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
    assign f3_in         = inst_i[14:12];
    assign unused_inst   = ^{inst_i[24:15], inst_i[11:7]};
    assign start         = (state == S_IDLE) && is_m && !flush_i;
    assign is_signed_div = !f3_in[0];
    assign div_zero      = (op2_i == '0);
    assign div_ovf       = is_signed_div && (op1_i == INT_MIN) && (op2_i == '1);
    assign div_special   = f3_in[2] && (div_zero || div_ovf);
    // Divide-by-zero: quotient all ones, remainder = dividend. Overflow: quotient INT_MIN, remainder 0.
    assign special_res   = div_zero ? (f3_in[1] ? op1_i : '1)
                                    : (f3_in[1] ? '0 : INT_MIN);
    assign op1_mag       = (is_signed_div && op1_i[XLEN-1]) ? -op1_i : op1_i;
    assign op2_mag       = (is_signed_div && op2_i[XLEN-1]) ? -op2_i : op2_i;

    // Multiplier: both operands extended to 2*XLEN so one unsigned product covers all signedness mixes
    logic            mul_a_sx, mul_b_sx;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0] mul_res;

    assign mul_a_sx = (f3_q[1:0] != 2'b11) && a_q[XLEN-1];
    assign mul_b_sx = !f3_q[1] && b_q[XLEN-1];
    assign mul_a    = {{XLEN{mul_a_sx}}, a_q};
    assign mul_b    = {{XLEN{mul_b_sx}}, b_q};
    assign prod     = mul_a * mul_b;
    assign mul_res  = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // One restoring-division step on magnitudes
    logic [XLEN:0]   partial, diff;
    logic            sub_ok;
    logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;

    assign partial = {rem_q, a_q[XLEN-1]};
    assign diff    = partial - {1'b0, b_q};
    assign sub_ok  = !diff[XLEN];
    assign rem_nxt = sub_ok ? diff[XLEN-1:0] : partial[XLEN-1:0];
    assign quo_nxt = {a_q[XLEN-2:0], sub_ok};
    assign div_res = f3_q[1] ? (neg_rem_q ? -rem_nxt : rem_nxt)
                             : (neg_quo_q ? -quo_nxt : quo_nxt);

    // Completion: the cycle before DONE, with the result and writeback target to register
    logic               fin;
    logic [XLEN-1:0]    fin_res;
    logic               fin_we;
    logic [RADDR_W-1:0] fin_rd;

    always_comb begin
        fin     = 1'b0;
        fin_res = special_res;
        fin_we  = we_q;
        fin_rd  = rd_q;
        if (start && div_special) begin
            fin    = 1'b1;
            fin_we = reg_we_i;
            fin_rd = reg_waddr_i;
        end else if (state == S_MUL && !flush_i) begin
            fin     = 1'b1;
            fin_res = mul_res;
        end else if (state == S_DIV && !flush_i && cnt_q == CNT_LAST) begin
            fin     = 1'b1;
            fin_res = div_res;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush aborts from any state except that DONE always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = div_special ? S_DONE : (f3_in[2] ? S_DIV : S_MUL);
            S_MUL:  state_nxt = flush_i ? S_IDLE : S_DONE;
            S_DIV:  if (flush_i) state_nxt = S_IDLE;
                    else if (cnt_q == CNT_LAST) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stall request: asserted combinationally on start and while an operation is in flight
    always_comb begin
        hold_o = start || (state == S_MUL) || (state == S_DIV);
    end

    // Operand capture, divide iteration and registered result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q            <= '0;
            b_q            <= '0;
            rem_q          <= '0;
            f3_q           <= '0;
            we_q           <= 1'b0;
            rd_q           <= '0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            cnt_q          <= '0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
            reg_we_o       <= 1'b0;
            reg_waddr_o    <= '0;
        end else begin
            result_valid_o <= 1'b0;
            reg_we_o       <= 1'b0;
            if (start) begin
                a_q       <= f3_in[2] ? op1_mag : op1_i;
                b_q       <= f3_in[2] ? op2_mag : op2_i;
                rem_q     <= '0;
                f3_q      <= f3_in;
                we_q      <= reg_we_i;
                rd_q      <= reg_waddr_i;
                neg_quo_q <= is_signed_div && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
                neg_rem_q <= is_signed_div && op1_i[XLEN-1];
                cnt_q     <= '0;
            end else if (state == S_DIV) begin
                a_q   <= quo_nxt;
                rem_q <= rem_nxt;
                cnt_q <= cnt_q + 1'b1;
            end
            if (fin) begin
                result_valid_o <= 1'b1;
                result_o       <= fin_res;
                reg_we_o       <= fin_we && (fin_rd != '0);
                reg_waddr_o    <= fin_rd;
            end
        end
    end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- RV32M multiply/divide unit in the execute stage.
- Consumes the operand, instruction and writeback fields registered by the ID/EX pipeline register.
- Runs the multi-cycle operation and drives hold_o back toward IF/ID/ID-EX to freeze the upstream pipeline until the result is ready.
- Presents a one-cycle result with writeback address and enable to the EX/MEM side.

Parameters:
- XLEN, 32, operand/result width.
- RADDR_W, 5, register address width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- op1_i  input  XLEN  rs1 value from ID/EX.
- op2_i  input  XLEN  rs2 value from ID/EX.
- inst_i  input  32  instruction from ID/EX.
- reg_we_i  input  1  writeback enable from ID/EX.
- reg_waddr_i  input  RADDR_W  rd from ID/EX.
- flush_i  input  1  abort current/pending operation (branch/trap).
- hold_o  output  1  stall request to upstream pipeline registers.
- result_valid_o  output  1  result strobe, one cycle.
- result_o  output  XLEN  result.
- reg_we_o  output  1  writeback enable qualified with result_valid_o.
- reg_waddr_o  output  RADDR_W  rd for the result.

Behaviour:
- Decode: is_m = (inst_i[6:0]==7'b0110011) & (inst_i[31:25]==7'b0000001). funct3 = inst_i[14:12].
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- start = (state==IDLE) & is_m & ~flush_i. On start, capture op1, op2, funct3, reg_we_i, reg_waddr_i.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on start with funct3[2]=0.
  - IDLE -> DIV on start with funct3[2]=1 and no special case.
  - IDLE -> DONE on start with div special case.
  - MUL -> DONE after 1 cycle.
  - DIV -> DONE after 32 iterations; counter runs 0..31 and exits on 31.
  - DONE -> IDLE unconditionally. No restart from DONE, so the same instruction is never re-executed.
- Latency, with the start cycle as cycle 0:
  - MUL family: result_valid_o high in cycle 2.
  - DIV family: result_valid_o high in cycle 33.
  - Div special case: result_valid_o high in cycle 1.
- hold_o is combinational. It is 1 when start is true, or when state is MUL or DIV. It is 0 in IDLE without start and 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Multiply: one 64-bit product computed in the MUL state.
  - Operands are sign- or zero-extended per funct3: MULHSU treats op1 as signed and op2 as unsigned.
  - MUL returns product[31:0]; the H variants return product[63:32].
- Divide: restoring radix-2 on magnitudes.
  - Signed ops use |op1| and |op2|.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, resolved at start:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op1.
  - Signed overflow (0x80000000 / -1): DIV returns 0x80000000; REM returns 0.
- Outputs are registered and set on entry to DONE.
  - result_valid_o = 1 for exactly one cycle.
  - reg_we_o = captured reg_we & (captured rd != 0).
  - result_valid_o is still 1 when rd = x0.
  - Outside DONE, result_valid_o = 0 and reg_we_o = 0. result_o and reg_waddr_o hold their last values.
- flush_i:
  - Aborts in any state: next state is IDLE, no result_valid_o, and hold_o drops in the next cycle.
  - flush_i asserted in the same cycle as a potential start suppresses the start; hold_o stays 0.
  - flush_i during DONE does not cancel that cycle's strobe; the pipeline owns the kill.
- Reset: state IDLE, counter 0, all outputs 0, including hold_o on the next cycle. Reset mid-operation discards the operation with no strobe.
- Non-M instructions: the unit stays IDLE and hold_o = 0.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), rd=x5 -> hold_o high in cycles 0-1; cycle 2: result_valid_o=1, result_o=0xFFFFFFEB, reg_we_o=1, reg_waddr_o=5.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100/7 -> hold_o high in cycles 0-32; cycle 33: result 14. REMU same operands -> 2. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- DIV 5/0 -> cycle 1: 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. In each case hold_o is high in cycle 0 only.
- DIVU started, then flush_i at iteration 10 -> no result_valid_o; hold_o is 0 in the next cycle. A second back-to-back MUL afterwards completes normally.
- rst_i pulsed mid-DIV -> all outputs 0 and no strobe. Separately, MUL with rd=x0 -> result_valid_o=1 and reg_we_o=0. A non-M instruction (ADD) -> hold_o stays 0.
